alu_control_sequencer: RTL
==========================

# alu_control_sequencer

Hard-wired control sequencer for the Phase-1 datapath's register-to-register ALU instructions. It replaces hand-driven control vectors with a registered state machine. Each instruction is fetched (T0–T2), its opcode and register fields are decoded from the datapath IR, and the execute steps (T3–T6) assert the datapath's bus-out, register-in, Y/Z and ALU strobes. It sits beside `datapath` and drives its control inputs directly.

## Interface
- `PC_INC_NONE` = 0: reserved; must stay 0 (IncPC is always used in T0).
- `clock`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `run`  in  1  level. While high, the block fetches and executes instructions back-to-back.
- `ir`  in  32  datapath IR output. Fields: `[31:27]` opcode, `[26:23]` Ra, `[22:19]` Rb, `[18:15]` Rc.
- `Rin`  out  16  one-hot R0in..R15in.
- `Rout`  out  16  one-hot R0out..R15out.
- `PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin, Zlowout, Zhighout, HIin, LOin`  out  1 each  datapath strobes.
- `alu_op`  out  13  one-hot ALU strobe. Bit order 0..12: ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, MUL, DIV, NEG, NOT.
- `done`  out  1  high during the final execute state of each instruction.
- `illegal`  out  1  one-cycle pulse on an undefined opcode.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6. The state is registered. All outputs are a combinational decode of the state and `ir`, with no other logic. Every output is 0 in IDLE.
- Opcodes:
  - ADD 00011, SUB 00100, AND 00101, OR 00110
  - ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011
  - MUL 01100, DIV 01101, NEG 01110, NOT 01111
  - Any other opcode is illegal.
- Fetch, common to all instructions:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Three-operand execute (ADD..SHL):
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], alu_op, Zin.
  - T5: Zlowout, Rin[Ra], done.
- Unary execute (NEG, NOT):
  - T3: Rout[Rb], Yin.
  - T4: alu_op, Zin (operand taken from Y).
  - T5: Zlowout, Rin[Ra], done.
- MUL, DIV:
  - T3: Rout[Ra], Yin.
  - T4: Rout[Rb], alu_op, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin, done.
- Transitions:
  - IDLE→T0 when `run`=1.
  - T0→T1→T2→T3 unconditionally.
  - T3: if the opcode is illegal, assert `illegal` during T3 with no other outputs, then go to IDLE. Otherwise go to T4.
  - T4→T5 unconditionally.
  - T5→T6 for MUL/DIV.
  - From the `done` state: go to T0 if `run`=1, else IDLE.
- `ir` is sampled only from T3 onward. The IR is loaded at the T2 edge, so it is valid throughout T3–T6.
- R0 is treated as an ordinary register here; this block does no R0-zero gating.

## Timing
- `clear`=1 forces IDLE immediately, with no clock needed, and all outputs drop to 0 combinationally. This holds mid-instruction too: the partially executed instruction is abandoned and no later strobe fires.
- After `clear` falls, the first T0 is on the first rising edge where `run`=1.
- Latency from T0 to done: 6 cycles for three-operand and unary ops, 7 for MUL/DIV. Back-to-back with `run` held high, the next T0 immediately follows the done cycle.
- If `run` drops mid-instruction, the current instruction completes and the block then returns to IDLE.
- Invariants in every state:
  - At most one bit of `Rout` is set.
  - At most one bus driver is active among `Rout`, PCout, MDRout, Zlowout and Zhighout.
  - `alu_op` is one-hot or zero.
  - `Read` is high only in T1.

## Test plan
- NEG R4,R7 (`ir`=0x72380000), memory returns it in T1, R7=0x0000000A:
  - T3: Rout=0x0080, Yin.
  - T4: alu_op bit11, Zin.
  - T5: Rin=0x0010, done.
  - Datapath R4 ends as 0xFFFFFFF6.
- ADD R1,R2,R3 (0x18918000):
  - T3: Rout=0x0004.
  - T4: Rout=0x0008, alu_op bit0.
  - T5: Rin=0x0002.
  - done exactly 6 cycles after T0.
- MUL R6,R7 (0x63380000), R6=3, R7=-2:
  - Block visits T0..T6.
  - LOin in T5, HIin in T6.
  - Result: LO=0xFFFFFFFA, HI=0xFFFFFFFF.
- `ir`=0xF8000000:
  - `illegal` is a single T3 pulse.
  - No Rin, Yin or Zin is ever asserted.
  - Block returns to IDLE.
- `run` held high across two ADDs: the second T0 is in the cycle right after the first done.
- `clear` pulsed for 3 ns during T4 of ADD:
  - Outputs go 0 within the pulse.
  - Rin is never asserted.
  - The state after the pulse is IDLE.

Source files
------------

// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: registered FSM that fetches and executes register-to-register ALU instructions on the datapath
//   clock, clear (async, active-high), run: control inputs; ir: datapath IR (opcode, Ra, Rb, Rc)
//   Rin/Rout: one-hot register strobes; PCout..LOin: datapath strobes; alu_op: one-hot ALU select
//   done: final execute state; illegal: T3 pulse on an undefined opcode
module alu_control_sequencer #(
  parameter int PC_INC_NONE = 0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zin,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic [12:0] alu_op,
  output logic        done,
  output logic        illegal
);
  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;
  state_t state, next;
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic legal, md, unary, unused;
  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];
  assign unused = &{1'b0, ir[14:0]};
  assign legal = op >= 5'd3 && op <= 5'd15;
  assign md = op == 5'd12 || op == 5'd13;
  assign unary = op == 5'd14 || op == 5'd15;
  always_ff @(posedge clock or posedge clear)
    if (clear) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state == IDLE ? (run ? T0 : IDLE) :
           state == T0 ? T1 :
           state == T1 ? T2 :
           state == T2 ? T3 :
           state == T3 ? (legal ? T4 : IDLE) :
           state == T4 ? T5 :
           state == T5 && md ? T6 :
           run ? T0 : IDLE;
    PCout = state == T0;
    MARin = state == T0;
    IncPC = state == T0 && PC_INC_NONE == 0;
    Zin = state == T0 || (state == T4 && legal);
    PCin = state == T1;
    Read = state == T1;
    MDRin = state == T1;
    MDRout = state == T2;
    IRin = state == T2;
    Yin = state == T3 && legal;
    Zlowout = state == T1 || (state == T5 && legal);
    Zhighout = state == T6;
    HIin = state == T6;
    LOin = state == T5 && legal && md;
    // MUL/DIV read Ra then Rb; the others read Rb then Rc, unary ops take only Y in T4
    Rout = state == T3 && legal ? 16'd1 << (md ? ra : rb) :
           state == T4 && legal && !unary ? 16'd1 << (md ? rb : rc) : 16'd0;
    Rin = state == T5 && legal && !md ? 16'd1 << ra : 16'd0;
    alu_op = state == T4 && legal ? 13'd1 << (op - 5'd3) : 13'd0;
    done = (state == T5 && legal && !md) || state == T6;
    illegal = state == T3 && !legal;
  end
endmodule
